// File: rtl/icache_refill_ctrl.sv
// Instruction-cache refill engine: on a miss, issues one incrementing burst
// read for the block, assembles the returned beats and writes the block into
// the cache with a single-cycle strobe (or pulses o_err if the burst failed).
module icache_refill_ctrl #(
  parameter int BLOCK_WIDTH = 512,
  parameter int BEAT_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 64
) (
  input  logic                   i_clk,
  input  logic                   i_arstn,
  input  logic                   i_miss,
  input  logic [ADDR_WIDTH-1:0]  i_miss_addr,
  output logic                   o_busy,
  output logic                   o_ar_valid,
  input  logic                   i_ar_ready,
  output logic [ADDR_WIDTH-1:0]  o_ar_addr,
  output logic [7:0]             o_ar_len,
  input  logic                   i_r_valid,
  output logic                   o_r_ready,
  input  logic [BEAT_WIDTH-1:0]  i_r_data,
  input  logic                   i_r_last,
  input  logic [1:0]             i_r_resp,
  output logic                   o_write_en,
  output logic [ADDR_WIDTH-1:0]  o_write_addr,
  output logic [BLOCK_WIDTH-1:0] o_instr_block,
  output logic                   o_err
);

  localparam int BEATS = BLOCK_WIDTH / BEAT_WIDTH;
  localparam int OFFS  = $clog2(BLOCK_WIDTH / 8);
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_WRITE,
    S_ERR
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [CW-1:0]          r_cnt;
  logic                   r_err;
  logic [BLOCK_WIDTH-1:0] r_block;
  logic                   w_beat;
  logic                   w_at_last;
  logic                   w_beat_bad;

  assign w_beat     = (r_state == S_FILL) && i_r_valid;
  assign w_at_last  = (r_cnt == CW'(BEATS - 1));
  // A beat is bad on an error response or when r_last disagrees with the count.
  assign w_beat_bad = (i_r_resp != 2'b00) || (i_r_last != w_at_last);

  assign o_busy        = (r_state != S_IDLE);
  assign o_instr_block = r_block;

  // State register.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and per-state output drive.
  always_comb begin
    w_next       = r_state;
    o_ar_valid   = 1'b0;
    o_ar_addr    = '0;
    o_ar_len     = '0;
    o_r_ready    = 1'b0;
    o_write_en   = 1'b0;
    o_write_addr = '0;
    o_err        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (i_miss) w_next = S_REQ;
      end
      S_REQ: begin
        o_ar_valid = 1'b1;
        o_ar_addr  = r_addr;
        o_ar_len   = 8'(BEATS - 1);
        if (i_ar_ready) w_next = S_FILL;
      end
      S_FILL: begin
        o_r_ready = 1'b1;
        if (w_beat && w_at_last) w_next = (r_err || w_beat_bad) ? S_ERR : S_WRITE;
      end
      S_WRITE: begin
        o_write_en   = 1'b1;
        o_write_addr = r_addr;
        w_next       = S_IDLE;
      end
      S_ERR: begin
        o_err  = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Miss address latch, beat counter, error flag and block assembly.
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      r_addr  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_block <= '0;
    end else begin
      if (r_state == S_IDLE && i_miss) begin
        r_addr <= {i_miss_addr[ADDR_WIDTH-1:OFFS], {OFFS{1'b0}}};
        r_cnt  <= '0;
        r_err  <= 1'b0;
      end
      if (w_beat) begin
        for (int unsigned k = 0; k < BEATS; k++) begin
          if (r_cnt == CW'(k)) r_block[k*BEAT_WIDTH +: BEAT_WIDTH] <= i_r_data;
        end
        r_cnt <= r_cnt + CW'(1);
        if (w_beat_bad) r_err <= 1'b1;
      end
      if (r_state == S_ERR) r_err <= 1'b0;
    end
  end

endmodule
